cmul_poly_sched: RTL and testbench

CMUL_POLY_SCHED -- requirements
Module: cmul_poly_sched

---
 rtl/cmul_poly_sched.sv | 139 +++++++++++++
 tb/tb_cmul_poly_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_poly_sched.sv
// Product of two first-order complex polynomials.
// One complex multiplier is time-shared across the four partial products.
module cmul_poly_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in,
    output logic        in_ready,
    output logic        busy,
    output logic        out_valid,
    output logic [35:0] out
);
    localparam int unsigned DW = 8;
    localparam int unsigned WW = 2 * DW;
    localparam int unsigned PW = 18;
    localparam int unsigned OW = 2 * PW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_ld_cnt;
    logic [1:0]           r_k;
    logic [WW-1:0]        r_a0, r_a1, r_b0, r_b1;
    logic [OW-1:0]        r_c0, r_c1, r_c2;
    logic [OW-1:0]        r_out, w_out_nxt;
    logic                 r_out_valid, w_out_valid_nxt;
    logic                 r_busy, r_in_ready;
    logic                 w_accept;
    logic [WW-1:0]        w_x, w_y;
    logic signed [DW-1:0] w_xr, w_xi, w_yr, w_yi;
    logic signed [WW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [PW-1:0] w_re, w_im;
    logic [OW-1:0]        w_prod;

    assign w_accept = in_valid && r_in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; r_k runs 0..3 in both MUL and OUT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && (r_ld_cnt == 2'd3)) w_state_nxt = S_MUL;
            S_MUL:   if (r_k == 2'd3) w_state_nxt = S_OUT;
            S_OUT:   if (r_k == 2'd3) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next value of the registered result port
    always_comb begin
        w_out_nxt       = '0;
        w_out_valid_nxt = 1'b0;
        if (r_state == S_OUT) begin
            case (r_k)
                2'd0: begin w_out_nxt = r_c0; w_out_valid_nxt = 1'b1; end
                2'd1: begin w_out_nxt = r_c1; w_out_valid_nxt = 1'b1; end
                2'd2: begin w_out_nxt = r_c2; w_out_valid_nxt = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_cnt    <= 2'd0;
            r_k         <= 2'd0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_k         <= (r_state == S_IDLE) ? 2'd0 : r_k + 2'd1;
            if (w_accept) r_ld_cnt <= r_ld_cnt + 2'd1;
        end
    end

    // Operand capture in arrival order; no reset since every slot is rewritten before use
    always_ff @(posedge clk) begin
        if (w_accept) begin
            case (r_ld_cnt)
                2'd0:    r_a0 <= in;
                2'd1:    r_a1 <= in;
                2'd2:    r_b0 <= in;
                default: r_b1 <= in;
            endcase
        end
    end

    // Shared multiplier: k = 0..3 selects (a0,b0) (a0,b1) (a1,b0) (a1,b1)
    assign w_x    = r_k[1] ? r_a1 : r_a0;
    assign w_y    = r_k[0] ? r_b1 : r_b0;
    assign w_xr   = w_x[WW-1:DW];
    assign w_xi   = w_x[DW-1:0];
    assign w_yr   = w_y[WW-1:DW];
    assign w_yi   = w_y[DW-1:0];
    assign w_p_rr = WW'(w_xr) * WW'(w_yr);
    assign w_p_ii = WW'(w_xi) * WW'(w_yi);
    assign w_p_ri = WW'(w_xr) * WW'(w_yi);
    assign w_p_ir = WW'(w_xi) * WW'(w_yr);
    assign w_re   = PW'(w_p_rr) - PW'(w_p_ii);
    assign w_im   = PW'(w_p_ri) + PW'(w_p_ir);
    assign w_prod = {w_re, w_im};

    // Coefficient registers; c1 accumulates the two cross terms
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c0 <= '0;
            r_c1 <= '0;
            r_c2 <= '0;
        end else if (r_state == S_MUL) begin
            case (r_k)
                2'd0:    r_c0 <= w_prod;
                2'd1:    r_c1 <= w_prod;
                2'd2:    r_c1 <= {r_c1[OW-1:PW] + w_re, r_c1[PW-1:0] + w_im};
                default: r_c2 <= w_prod;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule

// File: tb/tb_cmul_poly_sched.sv
// Self-checking bench for cmul_poly_sched: directed scenarios plus randomized
// transactions checked against an integer polynomial-product model.
module tb_cmul_poly_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] din = '0;
    logic        in_ready, busy, out_valid;
    logic [35:0] dout;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    cmul_poly_sched dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(din),
        .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .out(dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [35:0] pk(input int re, input int im);
        pk = {18'(re), 18'(im)};
    endfunction

    // Reference: words a0,a1,b0,b1; c0=a0*b0, c1=a0*b1+a1*b0, c2=a1*b1
    function automatic void poly(input logic [63:0] ws, output logic [35:0] c0,
                                 output logic [35:0] c1, output logic [35:0] c2);
        int r[4];
        int m[4];
        for (int i = 0; i < 4; i++) begin
            r[i] = $signed(ws[63-16*i -: 8]);
            m[i] = $signed(ws[55-16*i -: 8]);
        end
        c0 = pk(r[0]*r[2] - m[0]*m[2], r[0]*m[2] + m[0]*r[2]);
        c1 = pk(r[0]*r[3] - m[0]*m[3] + r[1]*r[2] - m[1]*m[2],
                r[0]*m[3] + m[0]*r[3] + r[1]*m[2] + m[1]*r[2]);
        c2 = pk(r[1]*r[3] - m[1]*m[3], r[1]*m[3] + m[1]*r[3]);
    endfunction

    task automatic wait_cyc(input int target);
        int t = 0;
        while (cyc < target && t < 200) begin
            @(posedge clk); #1; t++;
        end
    endtask

    // Loads four words with random idle gaps in [glo,ghi]; e0 = edge accepting word 4
    task automatic drive_txn(input logic [63:0] ws, input int glo, input int ghi, output int e0);
        e0 = 0;
        for (int i = 0; i < 4; i++) begin
            int g;
            int t;
            g = int'($urandom_range(ghi, glo));
            in_valid = 1'b0;
            repeat (g) begin
                din = 16'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            din = ws[63-16*i -: 16];
            t = 0;
            while (!in_ready && t < 64) begin
                @(posedge clk); #1; t++;
            end
            if (t >= 64) begin
                n_tests++; n_fail++;
                $display("FAIL load_timeout word %0d: in_ready stayed %0b, want 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            e0 = cyc;
        end
    endtask

    // Checks edges E1..E8 after the 4th-word accept
    task automatic check_burst(input int e0, input logic [35:0] c0, input logic [35:0] c1,
                               input logic [35:0] c2, input string tag, output int first_v);
        first_v = -1;
        for (int off = 1; off <= 8; off++) begin
            logic        ev;
            logic [35:0] eo;
            wait_cyc(e0 + off);
            ev = (off >= 5 && off <= 7);
            eo = (off == 5) ? c0 : (off == 6) ? c1 : (off == 7) ? c2 : 36'h0;
            if (out_valid === 1'b1 && first_v < 0) first_v = cyc;
            n_tests++;
            if (out_valid !== ev || dout !== eo) begin
                n_fail++;
                $display("FAIL %s E%0d out_valid/out got %0b/%h want %0b/%h",
                         tag, off, out_valid, dout, ev, eo);
            end
            n_tests++;
            if (busy !== (off < 8) || in_ready !== (off == 8)) begin
                n_fail++;
                $display("FAIL %s E%0d busy/in_ready got %0b/%0b want %0b/%0b",
                         tag, off, busy, in_ready, (off < 8), (off == 8));
            end
        end
    endtask

    localparam logic [63:0] BASIC_WS = 64'h0102_0000_0304_0000;
    localparam logic [35:0] BASIC_C0 = {18'h3FFFB, 18'h0000A};

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        din = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || dout !== 36'h0) begin
            n_fail++;
            $display("FAIL reset rdy/busy/vld/out got %0b/%0b/%0b/%h want 1/0/0/0",
                     in_ready, busy, out_valid, dout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int e0, fv;
        drive_txn(BASIC_WS, 0, 0, e0);
        check_burst(e0, BASIC_C0, 36'h0, 36'h0, "basic", fv);
    endtask

    task automatic test_extremes();
        int e0, fv;
        drive_txn(64'h8080_8080_8080_8080, 0, 0, e0);
        check_burst(e0, {18'h0, 18'h08000}, {18'h0, 18'h10000}, {18'h0, 18'h08000},
                    "extremes", fv);
    endtask

    task automatic test_gapped();
        int e0, fv;
        drive_txn(BASIC_WS, 3, 3, e0);
        check_burst(e0, BASIC_C0, 36'h0, 36'h0, "gapped", fv);
        n_tests++;
        if (fv - e0 !== 5) begin
            n_fail++;
            $display("FAIL gapped_latency got %0d edges want 5", fv - e0);
        end
    endtask

    task automatic test_busy_discard();
        int e0, fv;
        bit go;
        go = 1'b0;
        e0 = 0;
        fork
            begin
                drive_txn(BASIC_WS, 0, 1, e0);
                go = 1'b1;
                in_valid = 1'b1;
                din = 16'hFFFF;
                wait_cyc(e0 + 7);
                in_valid = 1'b0;
            end
            begin
                wait (go);
                check_burst(e0, BASIC_C0, 36'h0, 36'h0, "busy_discard", fv);
            end
        join
        test_basic();
    endtask

    task automatic test_reset_mid_out();
        int e0;
        drive_txn(BASIC_WS, 0, 0, e0);
        wait_cyc(e0 + 5);
        n_tests++;
        if (out_valid !== 1'b1 || dout !== BASIC_C0) begin
            n_fail++;
            $display("FAIL rst_out_pre out_valid/out got %0b/%h want 1/%h", out_valid, dout, BASIC_C0);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_tests++;
        if (out_valid !== 1'b0 || dout !== 36'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out vld/out/rdy/busy got %0b/%h/%0b/%0b want 0/0/1/0",
                     out_valid, dout, in_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_out_quiet cycle %0d out_valid got %0b want 0", i, out_valid);
            end
        end
        test_basic();
    endtask

    task automatic test_reset_mid_load();
        in_valid = 1'b1;
        din = 16'h7F7F;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_basic();
    endtask

    task automatic test_back_to_back();
        logic [63:0] wa, wb;
        logic [35:0] a0, a1, a2, b0, b1, b2;
        int ea, eb, fa, fb;
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        poly(wa, a0, a1, a2);
        poly(wb, b0, b1, b2);
        ea = 0;
        fork
            begin
                drive_txn(wa, 0, 0, ea);
                drive_txn(wb, 0, 0, eb);
            end
            begin
                wait (ea != 0);
                check_burst(ea, a0, a1, a2, "b2b_first", fa);
            end
        join
        check_burst(eb, b0, b1, b2, "b2b_second", fb);
        // Four load edges plus the eight-edge transaction separate the bursts
        n_tests++;
        if (fb - fa !== 12) begin
            n_fail++;
            $display("FAIL b2b_spacing got %0d edges want 12", fb - fa);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [63:0] ws;
            logic [35:0] c0, c1, c2;
            int e0, fv;
            ws = {$urandom, $urandom};
            poly(ws, c0, c1, c2);
            drive_txn(ws, 0, 2, e0);
            check_burst(e0, c0, c1, c2, "random", fv);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_gapped();
        test_busy_discard();
        test_reset_mid_out();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
